dvi_tmds_encoder: RTL
=====================

// Module: dvi_tmds_encoder
// PURPOSE
//  Three-channel DVI 1.0 TMDS encoder between the AXI2HDMI RGB output and the OSERDESE2 10:1 serialisers.
//  Turns 24-bit RGB plus DE/HSync/VSync, one pixel per px clock, into three DC-balanced 10-bit symbols.
//  Output bit [0] is transmitted first, so it drives serialiser D1.
//  Fixed 2-cycle pipeline; a running disparity counter per channel.
// PARAMETERS
//  CH_INVERT  3'b000  per-channel output polarity swap (bit n inverts all 10 bits of tmds_chn_o), for PCB P/N swaps
//  REG_IN     1'b1    1: register inputs (stage 0) giving 3-cycle latency; 0: 2-cycle latency
// PORTS
//  clk_i        in   1   pixel clock; only clock
//  rst_i        in   1   asynchronous, active-high reset
//  data_i       in   24  pixel: [23:16]=R, [15:8]=G, [7:0]=B
//  de_i         in   1   data enable (active video)
//  hsync_i      in   1   horizontal sync (polarity passed through)
//  vsync_i      in   1   vertical sync
//  tmds_ch0_o   out  10  blue symbol; carries {C1,C0}={vsync,hsync}
//  tmds_ch1_o   out  10  green symbol; C=00
//  tmds_ch2_o   out  10  red symbol; C=00
// BEHAVIOUR
//  Interface: one clock clk_i; reset rst_i is asynchronous and active-high.
//  Reset: all pipeline regs cleared, disparity cnt=0, de pipe=0; every output = CTRL_00 (10'h354), after CH_INVERT.
//  Latency: inputs sampled on cycle N appear on the outputs after cycle N+2 (REG_IN=0) or N+3 (REG_IN=1).
//   No stall and no handshake; a new pixel is accepted every cycle.
//  Stage 1 (transition minimisation, per channel, D=8-bit data):
//   n1=popcount(D); use_xnor = (n1>4) | (n1==4 & D[0]==0)
//   q_m[0]=D[0]; q_m[i]=q_m[i-1] XOR/XNOR D[i]; q_m[8]=~use_xnor. Register q_m, de, c[1:0].
//  Stage 2 (DC balance). cnt is signed 5-bit and stays even in [-8,+8].
//   N1=popcount(q_m[7:0]), N0=8-N1.
//   de=0: out=CTRL token {C1,C0}: 00->10'h354, 01->10'h0AB, 10->10'h154, 11->10'h2AB. Set cnt<=0.
//   de=1, cnt==0 or N1==N0: out={~q_m8, q_m8, q_m8?q_m[7:0]:~q_m[7:0]}
//     cnt += q_m8 ? N1-N0 : N0-N1
//   de=1, (cnt>0 & N1>N0)|(cnt<0 & N0>N1): out={1, q_m8, ~q_m[7:0]}; cnt += 2*q_m8 + (N0-N1)
//   else: out={0, q_m8, q_m[7:0]}; cnt += -2*~q_m8 + (N1-N0)
//  Disparity arithmetic is done in signed 6-bit, then truncated to 5 bits. Overflow cannot occur by construction; assert |cnt|<=8.
//  Blanking boundary: the first de=1 pixel after any de=0 cycle is encoded with cnt=0.
//  Reset mid-line: asynchronous clear. The first symbol after release is the control token for the then-current syncs.
//  X on data_i while de=0 must not propagate to the outputs or to cnt.
// STRUCTURE
//  tmds_pkg: typedef logic [9:0] tmds_sym_t; typedef logic signed [4:0] tmds_disp_t;
//   localparams CTRL_00..CTRL_11; function popcount8.
//  Sub-module tmds_channel_enc: one channel (stage 1 + stage 2 + cnt), instantiated 3x.
//   The top holds the REG_IN stage, channel/control mapping and CH_INVERT.
//  No vendor primitives; this block is synthesisable for ASIC and FPGA.
// TESTING
//  1 Reset, hold de=0, h=v=0 -> all ch = 10'h354; hsync=1 -> ch0 = 10'h0AB after latency; ch1/ch2 stay 10'h354.
//  2 de=1, B=8'h00 for 3 cycles from blanking -> ch0 = 10'h100, 10'h3FF, 10'h100; cnt = -8, +2, -6.
//  3 de=1, B=8'hFF from cnt=0 -> ch0 = 10'h200; cnt=-8; a de=0 cycle then returns cnt to 0.
//  4 Random 10^6 pixels with random blanking, checked against a golden C/SV model of DVI 1.0 fig.3-5.
//   Decode each symbol back and compare to the input; check |cnt|<=8 and running disparity bounded over every line.
//  5 Assert rst_i mid-active-line -> outputs 10'h354 in the same cycle (async); cnt=0; encoding is correct after release.
//  6 CH_INVERT=3'b101, de=0, C=00 -> ch0=ch2=10'h0AB, ch1=10'h354; data path inverted identically.

Source files
------------

// File: rtl/dvi_tmds_encoder_pkg.sv
// Shared types, control tokens and helpers for the three-channel DVI TMDS encoder.
package dvi_tmds_encoder_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DISP_W = 5;

  typedef logic [SYM_W-1:0]         tmds_sym_t;
  typedef logic signed [DISP_W-1:0] tmds_disp_t;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } rgb_t;

  localparam tmds_sym_t CTRL_00 = 10'h354;
  localparam tmds_sym_t CTRL_01 = 10'h0AB;
  localparam tmds_sym_t CTRL_10 = 10'h154;
  localparam tmds_sym_t CTRL_11 = 10'h2AB;

  function automatic logic [3:0] popcount8(input logic [DATA_W-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < int'(DATA_W); i++) n = n + 4'(v[i]);
    return n;
  endfunction

  function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
    tmds_sym_t t;
    case (c)
      2'b01:   t = CTRL_01;
      2'b10:   t = CTRL_10;
      2'b11:   t = CTRL_11;
      default: t = CTRL_00;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/dvi_tmds_encoder_if.sv
// Pixel-in / symbol-out bundle between the RGB source and the TMDS encoder.
interface dvi_tmds_encoder_if;
  import dvi_tmds_encoder_pkg::*;

  rgb_t      data_i;
  logic      de_i;
  logic      hsync_i;
  logic      vsync_i;
  tmds_sym_t tmds_ch0_o;
  tmds_sym_t tmds_ch1_o;
  tmds_sym_t tmds_ch2_o;

  modport master (
    output data_i, de_i, hsync_i, vsync_i,
    input  tmds_ch0_o, tmds_ch1_o, tmds_ch2_o
  );

  modport slave (
    input  data_i, de_i, hsync_i, vsync_i,
    output tmds_ch0_o, tmds_ch1_o, tmds_ch2_o
  );

endinterface

// File: rtl/dvi_tmds_encoder_channel.sv
// One TMDS channel: transition minimisation, then DC balancing with a running disparity count.
module dvi_tmds_encoder_channel
  import dvi_tmds_encoder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data,
  input  logic              de,
  input  logic [1:0]        ctrl,
  output tmds_sym_t         sym
);

  logic [3:0]  n1_d;
  logic        use_xnor;
  logic        acc;
  logic [8:0]  qm_d;
  logic [8:0]  qm_q;
  logic        de_q;
  logic [1:0]  ctrl_q;

  always_comb begin
    n1_d     = popcount8(data);
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !data[0]);
    acc      = data[0];
    qm_d     = 9'd0;
    qm_d[0]  = acc;
    for (int i = 1; i < int'(DATA_W); i++) begin
      acc     = use_xnor ? ~(acc ^ data[i]) : (acc ^ data[i]);
      qm_d[i] = acc;
    end
    qm_d[8] = ~use_xnor;
  end

  // Data is gated during blanking so undefined pixels never reach stage 2.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      qm_q   <= 9'd0;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      qm_q   <= de ? qm_d : 9'd0;
      de_q   <= de;
      ctrl_q <= ctrl;
    end
  end

  tmds_disp_t        cnt_q;
  tmds_disp_t        cnt_d;
  tmds_sym_t         sym_d;
  tmds_sym_t         sym_q;
  logic              q8;
  logic [3:0]        n1_m;
  logic signed [5:0] bal;
  logic signed [5:0] cnt_ext;
  logic signed [5:0] two_q8;
  logic signed [5:0] two_nq8;
  logic signed [5:0] cnt_sum;

  // bal = N1 - N0 = 2*N1 - 8; all disparity math in 6-bit signed.
  always_comb begin
    q8      = qm_q[8];
    n1_m    = popcount8(qm_q[7:0]);
    bal     = $signed({1'b0, n1_m, 1'b0}) - 6'sd8;
    cnt_ext = {cnt_q[DISP_W-1], cnt_q};
    two_q8  = {4'b0000, q8, 1'b0};
    two_nq8 = {4'b0000, ~q8, 1'b0};
    sym_d   = ctrl_token(ctrl_q);
    cnt_sum = 6'sd0;
    if (de_q) begin
      if ((cnt_q == 5'sd0) || (n1_m == 4'd4)) begin
        sym_d   = {~q8, q8, (q8 ? qm_q[7:0] : ~qm_q[7:0])};
        cnt_sum = q8 ? (cnt_ext + bal) : (cnt_ext - bal);
      end else if (((cnt_q > 5'sd0) && (n1_m > 4'd4)) || ((cnt_q < 5'sd0) && (n1_m < 4'd4))) begin
        sym_d   = {1'b1, q8, ~qm_q[7:0]};
        cnt_sum = cnt_ext + two_q8 - bal;
      end else begin
        sym_d   = {1'b0, q8, qm_q[7:0]};
        cnt_sum = cnt_ext - two_nq8 + bal;
      end
    end
    cnt_d = tmds_disp_t'(cnt_sum[DISP_W-1:0]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sym_q <= CTRL_00;
      cnt_q <= 5'sd0;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym = sym_q;

  a_cnt_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    (cnt_q >= -5'sd8) && (cnt_q <= 5'sd8));

endmodule

// File: rtl/dvi_tmds_encoder.sv
// Three-channel DVI TMDS encoder: optional input register, channel/sync mapping, P/N polarity swap.
module dvi_tmds_encoder
  import dvi_tmds_encoder_pkg::*;
#(
  parameter logic [2:0] CH_INVERT = 3'b000,
  parameter bit         REG_IN    = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dvi_tmds_encoder_if.slave  bus
);

  rgb_t px;
  logic px_de;
  logic px_hs;
  logic px_vs;

  generate
    if (REG_IN) begin : g_reg_in
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          px    <= '0;
          px_de <= 1'b0;
          px_hs <= 1'b0;
          px_vs <= 1'b0;
        end else begin
          px    <= bus.data_i;
          px_de <= bus.de_i;
          px_hs <= bus.hsync_i;
          px_vs <= bus.vsync_i;
        end
      end
    end else begin : g_no_reg_in
      always_comb begin
        px    = bus.data_i;
        px_de = bus.de_i;
        px_hs = bus.hsync_i;
        px_vs = bus.vsync_i;
      end
    end
  endgenerate

  tmds_sym_t sym0;
  tmds_sym_t sym1;
  tmds_sym_t sym2;

  // Only the blue channel carries the syncs during blanking.
  dvi_tmds_encoder_channel u_ch0 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .data  (px.b),
    .de    (px_de),
    .ctrl  ({px_vs, px_hs}),
    .sym   (sym0)
  );

  dvi_tmds_encoder_channel u_ch1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .data  (px.g),
    .de    (px_de),
    .ctrl  (2'b00),
    .sym   (sym1)
  );

  dvi_tmds_encoder_channel u_ch2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .data  (px.r),
    .de    (px_de),
    .ctrl  (2'b00),
    .sym   (sym2)
  );

  assign bus.tmds_ch0_o = sym0 ^ {SYM_W{CH_INVERT[0]}};
  assign bus.tmds_ch1_o = sym1 ^ {SYM_W{CH_INVERT[1]}};
  assign bus.tmds_ch2_o = sym2 ^ {SYM_W{CH_INVERT[2]}};

endmodule
